// File: rtl/id_ex_pkg.sv
// Shared constants and types for the ID/EX pipeline register and its hazard unit.
package id_ex_pkg;

    localparam int ALUCTRL_W = 2;
    localparam int FLAGW_W   = 2;
    localparam int COND_W    = 4;

    localparam logic [1:0] FWD_REGFILE    = 2'b00;
    localparam logic [1:0] FWD_RESULTW    = 2'b01;
    localparam logic [1:0] FWD_ALURESULTM = 2'b10;

    localparam logic [3:0] PC_REG = 4'd15;

    typedef struct packed {
        logic                 reg_write;
        logic                 mem_write;
        logic                 memto_reg;
        logic                 branch;
        logic                 alu_src;
        logic [ALUCTRL_W-1:0] alu_control;
        logic [FLAGW_W-1:0]   flag_write;
        logic [COND_W-1:0]    cond;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use stall, branch flush and operand-forwarding selection, all combinational.
module hazard_detect
    import id_ex_pkg::*;
#(
    parameter int RA_W = 4
) (
    input  logic            reg_write_e,
    input  logic            memto_reg_e,
    input  logic [RA_W-1:0] ra1_d,
    input  logic [RA_W-1:0] ra2_d,
    input  logic [RA_W-1:0] wa3_e,
    input  logic [RA_W-1:0] ra1_e,
    input  logic [RA_W-1:0] ra2_e,
    input  logic [RA_W-1:0] wa3_m,
    input  logic [RA_W-1:0] wa3_w,
    input  logic            reg_write_m,
    input  logic            reg_write_w,
    input  logic            branch_taken_e,
    output logic [1:0]      forward_a_e,
    output logic [1:0]      forward_b_e,
    output logic            stall_f,
    output logic            stall_d,
    output logic            flush_d,
    output logic            flush_e,
    output logic            ldr_stall
);

    localparam logic [RA_W-1:0] PC_ADDR = RA_W'(PC_REG);

    // Memory-stage result wins over writeback; reads of the PC are never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [RA_W-1:0] ra,
        input logic [RA_W-1:0] wa_m,
        input logic [RA_W-1:0] wa_w,
        input logic            we_m,
        input logic            we_w
    );
        if (we_m && (ra == wa_m) && (ra != PC_ADDR))
            return FWD_ALURESULTM;
        else if (we_w && (ra == wa_w) && (ra != PC_ADDR))
            return FWD_RESULTW;
        return FWD_REGFILE;
    endfunction

    always_comb begin
        ldr_stall   = memto_reg_e && reg_write_e && ((ra1_d == wa3_e) || (ra2_d == wa3_e));
        stall_f     = ldr_stall;
        stall_d     = ldr_stall;
        flush_d     = branch_taken_e;
        flush_e     = ldr_stall || branch_taken_e;
        forward_a_e = fwd_sel(ra1_e, wa3_m, wa3_w, reg_write_m, reg_write_w);
        forward_b_e = fwd_sel(ra2_e, wa3_m, wa3_w, reg_write_m, reg_write_w);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with integrated hazard unit.
// Define ID_EX_STALL_CNT_EN to add the saturating load-use stall counter output StallCnt.
module id_ex_stage
    import id_ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RA_W   = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
`ifdef ID_EX_STALL_CNT_EN
    output logic [31:0]          StallCnt,
`endif
    input  logic                 RegWriteD,
    input  logic                 MemWriteD,
    input  logic                 MemtoRegD,
    input  logic                 BranchD,
    input  logic                 ALUSrcD,
    input  logic [ALUCTRL_W-1:0] ALUControlD,
    input  logic [FLAGW_W-1:0]   FlagWriteD,
    input  logic [COND_W-1:0]    CondD,
    input  logic [DATA_W-1:0]    ReadData1D,
    input  logic [DATA_W-1:0]    ReadData2D,
    input  logic [DATA_W-1:0]    ExtImmD,
    input  logic [RA_W-1:0]      RA1D,
    input  logic [RA_W-1:0]      RA2D,
    input  logic [RA_W-1:0]      WA3D,
    input  logic [RA_W-1:0]      WA3M,
    input  logic [RA_W-1:0]      WA3W,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic                 BranchTakenE,
    output logic                 RegWriteE,
    output logic                 MemWriteE,
    output logic                 MemtoRegE,
    output logic                 BranchE,
    output logic                 ALUSrcE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic [FLAGW_W-1:0]   FlagWriteE,
    output logic [COND_W-1:0]    CondE,
    output logic [DATA_W-1:0]    ReadData1E,
    output logic [DATA_W-1:0]    ReadData2E,
    output logic [DATA_W-1:0]    ExtImmE,
    output logic [RA_W-1:0]      RA1E,
    output logic [RA_W-1:0]      RA2E,
    output logic [RA_W-1:0]      WA3E,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 FlushD,
    output logic                 FlushE
);

    ctrl_t             ctrl_d, ctrl_q;
    logic [DATA_W-1:0] rd1_d, rd1_q, rd2_d, rd2_q, imm_d, imm_q;
    logic [RA_W-1:0]   ra1_d, ra1_q, ra2_d, ra2_q, wa3_d, wa3_q;
    logic              ldr_stall;

    hazard_detect #(.RA_W(RA_W)) u_hazard (
        .reg_write_e    (ctrl_q.reg_write),
        .memto_reg_e    (ctrl_q.memto_reg),
        .ra1_d          (RA1D),
        .ra2_d          (RA2D),
        .wa3_e          (wa3_q),
        .ra1_e          (ra1_q),
        .ra2_e          (ra2_q),
        .wa3_m          (WA3M),
        .wa3_w          (WA3W),
        .reg_write_m    (RegWriteM),
        .reg_write_w    (RegWriteW),
        .branch_taken_e (BranchTakenE),
        .forward_a_e    (ForwardAE),
        .forward_b_e    (ForwardBE),
        .stall_f        (StallF),
        .stall_d        (StallD),
        .flush_d        (FlushD),
        .flush_e        (FlushE),
        .ldr_stall      (ldr_stall)
    );

    // A flush loads an all-zero bubble; there is deliberately no hold path.
    always_comb begin
        ctrl_d = '0;
        rd1_d  = '0;
        rd2_d  = '0;
        imm_d  = '0;
        ra1_d  = '0;
        ra2_d  = '0;
        wa3_d  = '0;
        if (!FlushE) begin
            ctrl_d = '{RegWriteD, MemWriteD, MemtoRegD, BranchD, ALUSrcD,
                       ALUControlD, FlagWriteD, CondD};
            rd1_d  = ReadData1D;
            rd2_d  = ReadData2D;
            imm_d  = ExtImmD;
            ra1_d  = RA1D;
            ra2_d  = RA2D;
            wa3_d  = WA3D;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q <= '0;
            rd1_q  <= '0;
            rd2_q  <= '0;
            imm_q  <= '0;
            ra1_q  <= '0;
            ra2_q  <= '0;
            wa3_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            imm_q  <= imm_d;
            ra1_q  <= ra1_d;
            ra2_q  <= ra2_d;
            wa3_q  <= wa3_d;
        end
    end

    assign RegWriteE   = ctrl_q.reg_write;
    assign MemWriteE   = ctrl_q.mem_write;
    assign MemtoRegE   = ctrl_q.memto_reg;
    assign BranchE     = ctrl_q.branch;
    assign ALUSrcE     = ctrl_q.alu_src;
    assign ALUControlE = ctrl_q.alu_control;
    assign FlagWriteE  = ctrl_q.flag_write;
    assign CondE       = ctrl_q.cond;
    assign ReadData1E  = rd1_q;
    assign ReadData2E  = rd2_q;
    assign ExtImmE     = imm_q;
    assign RA1E        = ra1_q;
    assign RA2E        = ra2_q;
    assign WA3E        = wa3_q;

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stall_cnt_d, stall_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (ldr_stall && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign StallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomised and directed bench for id_ex_stage against a cycle-level reference model.
module tb_id_ex_stage;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        memto_reg;
        logic        branch;
        logic        alu_src;
        logic [1:0]  alu_control;
        logic [1:0]  flag_write;
        logic [3:0]  cond;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic [3:0]  wa3;
    } dec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    dec_t din = '0;
    logic [3:0] wa3m = '0, wa3w = '0;
    logic rwm = 1'b0, rww = 1'b0, bte = 1'b0;

    logic RegWriteE, MemWriteE, MemtoRegE, BranchE, ALUSrcE;
    logic [1:0] ALUControlE, FlagWriteE, ForwardAE, ForwardBE;
    logic [3:0] CondE, RA1E, RA2E, WA3E;
    logic [31:0] ReadData1E, ReadData2E, ExtImmE;
    logic StallF, StallD, FlushD, FlushE;
`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] StallCnt;
`endif

    dec_t me;
    logic [31:0] mcnt;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .RA_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
`ifdef ID_EX_STALL_CNT_EN
        .StallCnt(StallCnt),
`endif
        .RegWriteD(din.reg_write), .MemWriteD(din.mem_write), .MemtoRegD(din.memto_reg),
        .BranchD(din.branch), .ALUSrcD(din.alu_src), .ALUControlD(din.alu_control),
        .FlagWriteD(din.flag_write), .CondD(din.cond),
        .ReadData1D(din.rd1), .ReadData2D(din.rd2), .ExtImmD(din.imm),
        .RA1D(din.ra1), .RA2D(din.ra2), .WA3D(din.wa3),
        .WA3M(wa3m), .WA3W(wa3w), .RegWriteM(rwm), .RegWriteW(rww), .BranchTakenE(bte),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
        .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .FlagWriteE(FlagWriteE), .CondE(CondE),
        .ReadData1E(ReadData1E), .ReadData2E(ReadData2E), .ExtImmE(ExtImmE),
        .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference rules: a load in E blocks a consumer in D; forwarding prefers M over W, never for r15.
    function automatic logic m_ldr();
        return me.memto_reg && me.reg_write && (din.ra1 == me.wa3 || din.ra2 == me.wa3);
    endfunction

    function automatic logic [1:0] m_fwd(input logic [3:0] ra);
        if (ra == 4'd15) return 2'd0;
        if (rwm && ra == wa3m) return 2'd2;
        if (rww && ra == wa3w) return 2'd1;
        return 2'd0;
    endfunction

    task automatic check_model();
        dec_t eout;
        #1;
        eout = {RegWriteE, MemWriteE, MemtoRegE, BranchE, ALUSrcE, ALUControlE, FlagWriteE,
                CondE, ReadData1E, ReadData2E, ExtImmE, RA1E, RA2E, WA3E};
        chk("e_regs", 128'(eout), 128'(me));
        chk("fwd_a", 128'(ForwardAE), 128'(m_fwd(me.ra1)));
        chk("fwd_b", 128'(ForwardBE), 128'(m_fwd(me.ra2)));
        chk("stall_f", 128'(StallF), 128'(m_ldr()));
        chk("stall_d", 128'(StallD), 128'(m_ldr()));
        chk("flush_d", 128'(FlushD), 128'(bte));
        chk("flush_e", 128'(FlushE), 128'(m_ldr() || bte));
`ifdef ID_EX_STALL_CNT_EN
        chk("stall_cnt", 128'(StallCnt), 128'(mcnt));
`endif
    endtask

    task automatic tick();
        dec_t nxt;
        logic st;
        st  = m_ldr();
        nxt = (st || bte) ? dec_t'('0) : din;
        if (st && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 1;
        @(posedge clk);
        #1;
        me = nxt;
    endtask

    // Reset lands mid-cycle and releases before the next rising edge.
    task automatic async_reset();
        #1 reset_n = 1'b0;
        #1;
        me   = '0;
        mcnt = '0;
        chk("rst_imm", 128'(ExtImmE), 128'(0));
        check_model();
        #1 reset_n = 1'b1;
    endtask

    task automatic quiet();
        din = '0; bte = 0; rwm = 0; rww = 0; wa3m = 0; wa3w = 0;
    endtask

    task automatic load_use(input logic [3:0] r);
        din = '0; din.reg_write = 1; din.memto_reg = 1; din.wa3 = r; din.ra1 = 4'd7; din.ra2 = 4'd8;
        check_model();
        tick();
        din = '0; din.reg_write = 1; din.ra1 = r; din.ra2 = 4'd9; din.wa3 = 4'd4;
        check_model();
        tick();
    endtask

    function automatic logic [3:0] rnd_ra();
        return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    endfunction

    initial begin
        me   = '0;
        mcnt = '0;
        #3;
        check_model();
        chk("rst_fwd_a", 128'(ForwardAE), 128'(0));
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Load-use: stall one cycle, bubble, then forward from writeback.
        din = '0; din.reg_write = 1; din.memto_reg = 1; din.wa3 = 4'd3; din.ra1 = 4'd7; din.ra2 = 4'd8;
        check_model();
        tick();
        din = '0; din.reg_write = 1; din.ra1 = 4'd3; din.ra2 = 4'd9; din.wa3 = 4'd4;
        check_model();
        chk("lu_stall_f", 128'(StallF), 128'(1));
        chk("lu_stall_d", 128'(StallD), 128'(1));
        chk("lu_flush_e", 128'(FlushE), 128'(1));
        tick();
        rwm = 1; wa3m = 4'd3;
        check_model();
        chk("lu_bubble", 128'(RegWriteE), 128'(0));
        chk("lu_stall_clr", 128'(StallF), 128'(0));
        tick();
        rwm = 0; rww = 1; wa3w = 4'd3;
        din = '0;
        check_model();
        chk("lu_fwd_w", 128'(ForwardAE), 128'(2'b01));

        // M forward, then M still wins over W.
        quiet();
        din.reg_write = 1; din.ra2 = 4'd5; din.ra1 = 4'd1; din.wa3 = 4'd6;
        tick();
        din = '0;
        rwm = 1; wa3m = 4'd5;
        check_model();
        chk("m_fwd_b", 128'(ForwardBE), 128'(2'b10));
        rww = 1; wa3w = 4'd5;
        check_model();
        chk("m_over_w", 128'(ForwardBE), 128'(2'b10));

        // R15 is never forwarded.
        quiet();
        din.ra1 = 4'd15;
        tick();
        din = '0;
        rwm = 1; wa3m = 4'd15;
        check_model();
        chk("r15_fwd_a", 128'(ForwardAE), 128'(2'b00));

        // Taken branch flushes E.
        quiet();
        bte = 1; din.rd1 = 32'hDEAD_BEEF; din.mem_write = 1; din.reg_write = 1;
        check_model();
        chk("br_flush_d", 128'(FlushD), 128'(1));
        tick();
        bte = 0;
        check_model();
        chk("br_rd1", 128'(ReadData1E), 128'(0));
        chk("br_memw", 128'(MemWriteE), 128'(0));

        // Load-use and branch together: flush while still stalling.
        quiet();
        din.reg_write = 1; din.memto_reg = 1; din.wa3 = 4'd2;
        tick();
        din = '0; din.ra2 = 4'd2; din.reg_write = 1; bte = 1;
        check_model();
        chk("both_stall", 128'(StallD), 128'(1));
        tick();
        chk("both_bubble", 128'(RegWriteE), 128'(0));
        quiet();

        // Asynchronous reset mid-cycle.
        din.imm = 32'h0000_00FF;
        tick();
        check_model();
        chk("pre_rst_imm", 128'(ExtImmE), 128'(32'hFF));
        async_reset();
        tick();

`ifdef ID_EX_STALL_CNT_EN
        async_reset();
        quiet();
        tick();
        for (int i = 0; i < 3; i++) load_use(4'd3);
        quiet();
        check_model();
        chk("cnt_three", 128'(StallCnt), 128'(3));
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        mcnt = 32'hFFFF_FFFF;
        load_use(4'd6);
        quiet();
        check_model();
        chk("cnt_sat", 128'(StallCnt), 128'(32'hFFFF_FFFF));
`endif

        // Randomised traffic with occasional mid-cycle resets.
        for (int i = 0; i < 400; i++) begin
            din.reg_write   = 1'($urandom);
            din.mem_write   = 1'($urandom);
            din.memto_reg   = ($urandom_range(0, 2) == 0);
            din.branch      = 1'($urandom);
            din.alu_src     = 1'($urandom);
            din.alu_control = 2'($urandom);
            din.flag_write  = 2'($urandom);
            din.cond        = 4'($urandom);
            din.rd1         = $urandom;
            din.rd2         = $urandom;
            din.imm         = $urandom;
            din.ra1         = rnd_ra();
            din.ra2         = rnd_ra();
            din.wa3         = rnd_ra();
            wa3m            = rnd_ra();
            wa3w            = rnd_ra();
            rwm             = 1'($urandom);
            rww             = 1'($urandom);
            bte             = ($urandom_range(0, 5) == 0);
            check_model();
            if ($urandom_range(0, 49) == 0) async_reset();
            else tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
